// File: rtl/inst_fetch_stage_pkg.sv
// Shared widths, defaults and slot types for the instruction fetch front end.
package inst_fetch_stage_pkg;

  localparam int PC_W              = 32;
  localparam int INST_W            = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam int DROP_W            = 8;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam pc_t RESET_PC_DEFAULT = '0;

  typedef struct packed {
    inst_t inst;
    pc_t   npc;
  } fetch_slot_t;

  function automatic pc_t pc_advance(input pc_t pc, input pc_t step);
    return pc + step;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Instruction-memory, redirect and decoder handshakes of the fetch stage.
interface inst_fetch_stage_if;
  import inst_fetch_stage_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  pc_t   imem_req_addr;
  logic  imem_resp_valid;
  inst_t imem_resp_inst;
  logic  redirect_valid;
  pc_t   redirect_pc;
  logic  dec_valid;
  logic  dec_ready;
  inst_t dec_inst;
  pc_t   dec_npc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_npc,
    input  imem_req_ready, imem_resp_valid, imem_resp_inst,
    input  redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_npc,
    output imem_req_ready, imem_resp_valid, imem_resp_inst,
    output redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/inst_fetch_stage_fetch_slot_queue.sv
// In-order slot queue: slots are allocated at request time and filled by responses.
module fetch_slot_queue
  import inst_fetch_stage_pkg::*;
#(
  parameter  int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alloc,
  input  pc_t               i_alloc_npc,
  input  logic              i_fill,
  input  inst_t             i_fill_inst,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic              o_head_filled,
  output fetch_slot_t       o_head,
  output logic [CNT_W-1:0]  o_alloc_cnt,
  output logic [CNT_W-1:0]  o_pending_cnt
);

  pc_t               r_npc  [DEPTH];
  inst_t             r_inst [DEPTH];
  logic [DEPTH-1:0]  r_filled;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  r_fill_ptr;
  logic [CNT_W-1:0]  r_alloc_cnt;
  logic [CNT_W-1:0]  r_pending_cnt;
  logic              w_fill;

  assign w_fill = i_fill && (r_pending_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filled      <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_fill_ptr    <= '0;
      r_alloc_cnt   <= '0;
      r_pending_cnt <= '0;
    end else if (i_flush) begin
      r_filled      <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_fill_ptr    <= '0;
      r_alloc_cnt   <= '0;
      r_pending_cnt <= '0;
    end else begin
      if (i_alloc) begin
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + PTR_W'(1);
      end
      if (w_fill) begin
        r_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + PTR_W'(1);
      end
      // A popped slot is cleared so the head never lands on a stale filled flag after wrap
      if (i_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + PTR_W'(1);
      end
      r_alloc_cnt   <= r_alloc_cnt + CNT_W'(i_alloc) - CNT_W'(i_pop);
      r_pending_cnt <= r_pending_cnt + CNT_W'(i_alloc) - CNT_W'(w_fill);
    end
  end

  // Payload carries no reset; r_filled alone decides whether a slot is visible
  always_ff @(posedge clk) begin
    if (i_alloc) r_npc[r_tail]      <= i_alloc_npc;
    if (w_fill)  r_inst[r_fill_ptr] <= i_fill_inst;
  end

  assign o_head_filled = r_filled[r_head];
  assign o_head.inst   = r_filled[r_head] ? r_inst[r_head] : '0;
  assign o_head.npc    = r_filled[r_head] ? r_npc[r_head]  : '0;
  assign o_alloc_cnt   = r_alloc_cnt;
  assign o_pending_cnt = r_pending_cnt;

endmodule

// File: rtl/inst_fetch_stage.sv
// Fetch front end: PC, memory request issue, stale-response dropping and redirect control.
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
#(
  parameter int  QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
  parameter pc_t RESET_PC    = RESET_PC_DEFAULT,
  parameter int  PC_STEP     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_stage_if.master bus
);

  localparam int  CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam pc_t STEP  = pc_t'(PC_STEP);

  pc_t               r_pc;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_fire;
  logic              w_drop_busy;
  logic              w_fill;
  logic              w_pop;
  logic              w_head_filled;
  fetch_slot_t       w_head;
  logic [CNT_W-1:0]  w_alloc_cnt;
  logic [CNT_W-1:0]  w_pending_cnt;
  logic [DROP_W-1:0] w_drop_sum;
  logic [DROP_W-1:0] w_drop_next;

  // Requests are held off during reset so the memory side sees nothing until release
  assign bus.imem_req_valid = rst_n && !bus.redirect_valid &&
                              (w_alloc_cnt < CNT_W'(QUEUE_DEPTH));
  assign bus.imem_req_addr  = r_pc;
  assign w_fire             = bus.imem_req_valid && bus.imem_req_ready;

  assign w_drop_busy = (r_drop_cnt != '0);
  assign w_fill      = bus.imem_resp_valid && !bus.redirect_valid && !w_drop_busy;
  assign w_pop       = bus.dec_valid && bus.dec_ready && !bus.redirect_valid;

  // Every read still in flight at a redirect becomes one more response to discard
  always_comb begin
    w_drop_sum  = r_drop_cnt + DROP_W'(w_pending_cnt);
    w_drop_next = r_drop_cnt;
    if (bus.redirect_valid) begin
      w_drop_next = w_drop_sum;
      if (bus.imem_resp_valid && (w_drop_sum != '0))
        w_drop_next = w_drop_sum - DROP_W'(1);
    end else if (bus.imem_resp_valid && w_drop_busy) begin
      w_drop_next = r_drop_cnt - DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_next;
      if (bus.redirect_valid)
        r_pc <= bus.redirect_pc;
      else if (w_fire)
        r_pc <= pc_advance(r_pc, STEP);
    end
  end

  fetch_slot_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_alloc       (w_fire),
    .i_alloc_npc   (pc_advance(r_pc, STEP)),
    .i_fill        (w_fill),
    .i_fill_inst   (bus.imem_resp_inst),
    .i_pop         (w_pop),
    .i_flush       (bus.redirect_valid),
    .o_head_filled (w_head_filled),
    .o_head        (w_head),
    .o_alloc_cnt   (w_alloc_cnt),
    .o_pending_cnt (w_pending_cnt)
  );

  assign bus.dec_valid = w_head_filled;
  assign bus.dec_inst  = w_head.inst;
  assign bus.dec_npc   = w_head.npc;

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.imem_resp_valid && !bus.redirect_valid && !w_drop_busy) |-> (w_pending_cnt != '0));

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Randomized scoreboard bench for inst_fetch_stage with an in-order variable-latency memory.
module tb_inst_fetch_stage;
  import inst_fetch_stage_pkg::*;

  localparam int  DEPTH  = 4;
  localparam pc_t RST_PC = 32'h0000_0000;

  typedef struct { inst_t inst; pc_t npc; } exp_t;
  typedef struct { pc_t addr; int due; } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  inst_fetch_stage_if bus();

  inst_fetch_stage #(
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (RST_PC),
    .PC_STEP     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rel_cyc = 0;
  int   first_dv = -1;
  int   dv_cnt = 0;
  int   fire_cnt = 0;
  int   lat_min = 1, lat_max = 1;
  int   rdy_pct = 100, drdy_pct = 100, redir_pct = 0;
  logic force_redir = 1'b0;
  pc_t  force_pc = '0;
  pc_t  model_pc = RST_PC;
  exp_t exp_q[$];
  rd_t  mem_q[$];

  function automatic inst_t mem_word(input pc_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic wait_npc(input pc_t want, input string nm);
    int n = 0;
    do begin
      @(negedge clk); #4;
      n++;
    end while (!bus.dec_valid && n < 60);
    if (!bus.dec_valid) begin
      total++;
      bad++;
      $display("FAIL %s: actual=no dec_valid in 60 cycles required npc=%0h", nm, want);
    end else begin
      check(nm, bus.dec_npc, want);
    end
  endtask

  // Stimulus and memory: drives inputs at negedge, records what fires at the coming posedge
  initial begin : driver
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.dec_ready       = 1'b0;
        continue;
      end
      bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
      bus.dec_ready      = ($urandom_range(99) < drdy_pct);
      if (force_redir) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = force_pc;
        force_redir        = 1'b0;
      end else if ($urandom_range(99) < redir_pct) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc_t'($urandom_range(0, 1023) * 4);
      end else begin
        bus.redirect_valid = 1'b0;
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_inst  = mem_word(mem_q[0].addr);
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst  = inst_t'($urandom);
      end
      #3;
      if (!rst_n) continue;
      if (bus.imem_resp_valid) void'(mem_q.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("req_addr", bus.imem_req_addr, model_pc);
        mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
        exp_q.push_back('{inst: mem_word(model_pc), npc: model_pc + 32'd4});
        model_pc = model_pc + 32'd4;
        fire_cnt++;
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        model_pc = bus.redirect_pc;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        check("req_valid_rule", bus.imem_req_valid,
              (!bus.redirect_valid && exp_q.size() < DEPTH));
        if (bus.dec_valid) begin
          dv_cnt++;
          if (first_dv < 0) first_dv = cyc - rel_cyc;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dec_orphan: actual dec_valid=1 npc=%0h required no output", bus.dec_npc);
          end else begin
            check("dec_npc", bus.dec_npc, exp_q[0].npc);
            check("dec_inst", bus.dec_inst, exp_q[0].inst);
            if (bus.dec_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : main
    int f0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_inst  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.dec_ready       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dec_valid", bus.dec_valid, 1'b0);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_dec_inst", bus.dec_inst, 32'h0);
    check("rst_dec_npc", bus.dec_npc, 32'h0);

    // streaming with 1-cycle memory and an always-ready decoder
    @(posedge clk); #2;
    rel_cyc = cyc;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #4;
    check("first_dec_valid_cycle", first_dv, 3);
    check("dec_valid_per_cycle", dv_cnt, 8);

    // decoder stalled: exactly DEPTH requests, then fetch stops with outputs held
    drdy_pct = 0; force_pc = 32'h40; force_redir = 1'b1;
    @(negedge clk); #4;
    f0 = fire_cnt;
    repeat (12) @(negedge clk);
    #4;
    check("stall_fire_count", fire_cnt - f0, DEPTH);
    check("stall_req_valid", bus.imem_req_valid, 1'b0);
    check("stall_dec_valid", bus.dec_valid, 1'b1);
    check("stall_dec_npc", bus.dec_npc, 32'h44);
    check("stall_dec_inst", bus.dec_inst, mem_word(32'h40));
    drdy_pct = 100;
    repeat (10) @(negedge clk);

    // three reads pending, redirect lands with a response in the same cycle
    #4;
    rdy_pct = 0; lat_min = 3; lat_max = 3; force_pc = 32'h80; force_redir = 1'b1;
    repeat (10) @(negedge clk);
    #4;
    rdy_pct = 100;
    repeat (3) @(negedge clk);
    #4;
    force_pc = 32'h100; force_redir = 1'b1;
    @(negedge clk);
    wait_npc(32'h104, "redirect_first_npc");

    // back-to-back redirects
    #1;
    force_pc = 32'h200; force_redir = 1'b1;
    @(negedge clk); #4;
    force_pc = 32'h300; force_redir = 1'b1;
    @(negedge clk);
    wait_npc(32'h304, "double_redirect_npc");

    // PC wrap at the top of the address space
    #1;
    force_pc = 32'hFFFF_FFF8; force_redir = 1'b1;
    @(negedge clk);
    wait_npc(32'hFFFF_FFFC, "wrap_npc");

    // random traffic
    #1;
    lat_min = 1; lat_max = 5; rdy_pct = 70; drdy_pct = 60; redir_pct = 3;
    repeat (3000) @(negedge clk);

    // reset with the queue full and stale reads still to drop
    #4;
    redir_pct = 0; drdy_pct = 0; rdy_pct = 100; lat_min = 8; lat_max = 8;
    repeat (6) @(negedge clk);
    #4;
    force_pc = 32'h500; force_redir = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_dec_valid", bus.dec_valid, 1'b0);
    check("midrst_req_valid", bus.imem_req_valid, 1'b0);
    mem_q.delete();
    exp_q.delete();
    model_pc = RST_PC;
    repeat (2) @(posedge clk);
    #2;
    lat_min = 1; lat_max = 1; drdy_pct = 100;
    rst_n = 1'b1;
    wait_npc(RST_PC + 32'd4, "restart_npc");
    repeat (10) @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
